hwpe_stream_source_realign_line: RTL and testbench

- Byte-granular stream realigner for HWPE source (load) paths.
- Consumes word-aligned TCDM load data and emits line-structured words shifted by a configurable byte offset.
- Next generation of the strobe-driven source realigner:
  - Offset, line length and line count are programmed explicitly.
  - Word/line counting is internal, so the block is inherently decoupled from address generation (load FIFOs allowed).
  - Adds multi-line operation, per-line last-word strobe trimming, a line-last flag and done signalling.
- Sits between the source's TCDM load FIFO and the engine-side stream.

---
 rtl/hwpe_stream_source_realign_line_if.sv | 14 +
 rtl/hwpe_stream_source_realign_line.sv | 191 +++++++++++++++++++
 tb/tb_hwpe_stream_source_realign_line.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_source_realign_line_if.sv
// Valid/ready word stream carrying data plus a byte strobe.
interface hwpe_stream_source_realign_line_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_source_realign_line.sv
// Byte-granular line realigner: turns word-aligned load data into lines of L
// output words starting at byte offset o, with last-word strobe trimming.
module hwpe_stream_source_realign_line #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   cfg_offset_i,
  input  logic [LEN_WIDTH-1:0]              cfg_line_length_i,
  input  logic [LEN_WIDTH-1:0]              cfg_num_lines_i,
  input  logic [DATA_WIDTH/8-1:0]           cfg_last_strb_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              line_last_o,
  hwpe_stream_source_realign_line_if.sink   stream_i,
  hwpe_stream_source_realign_line_if.source stream_o
);

  localparam int unsigned B     = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(B);
  localparam int unsigned SH_W  = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [OFF_W-1:0]      r_offset;
  logic [LEN_WIDTH-1:0]  r_len_m1;
  logic [LEN_WIDTH-1:0]  r_lines_m1;
  logic [B-1:0]          r_last_strb;
  logic [LEN_WIDTH-1:0]  r_word_cnt;
  logic [LEN_WIDTH-1:0]  r_line_cnt;
  logic [DATA_WIDTH-1:0] r_h;

  logic                  w_has_off;
  logic                  w_job_empty;
  logic                  w_word_last;
  logic                  w_line_last;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [SH_W-1:0]       w_rsh;
  logic [SH_W-1:0]       w_lsh;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_unused_strb;

  assign w_unused_strb = ^stream_i.strb;

  assign w_has_off   = (r_offset != '0);
  assign w_job_empty = (cfg_line_length_i == '0) || (cfg_num_lines_i == '0);
  // L-1 and N-1 are latched at start, so L=N=2^LEN_WIDTH-1 never overflows
  assign w_word_last = (r_word_cnt == r_len_m1);
  assign w_line_last = (r_line_cnt == r_lines_m1);
  assign w_in_hs     = stream_i.valid && stream_i.ready;
  assign w_out_hs    = stream_o.valid && stream_o.ready;

  assign w_rsh     = SH_W'({r_offset, 3'b000});
  assign w_lsh     = SH_W'(DATA_WIDTH) - w_rsh;
  assign w_shifted = (r_h >> w_rsh) | (stream_i.data << w_lsh);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else if (clear_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    line_last_o    = 1'b0;
    stream_i.ready = 1'b0;
    stream_o.valid = 1'b0;
    stream_o.data  = w_has_off ? w_shifted : stream_i.data;
    stream_o.strb  = '1;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_job_empty) begin
            w_state_nxt = S_DONE;
          end else if (cfg_offset_i != '0) begin
            w_state_nxt = S_FIRST;
          end else begin
            w_state_nxt = S_STREAM;
          end
        end
      end
      S_FIRST: begin
        busy_o         = 1'b1;
        stream_i.ready = 1'b1;
        if (stream_i.valid) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        busy_o         = 1'b1;
        stream_o.valid = stream_i.valid;
        stream_i.ready = stream_o.ready;
        line_last_o    = w_word_last;
        stream_o.strb  = w_word_last ? r_last_strb : '1;
        // With an offset each line re-absorbs its own head word in FIRST
        if (w_out_hs && w_word_last) begin
          if (w_line_last) begin
            w_state_nxt = S_DONE;
          end else if (w_has_off) begin
            w_state_nxt = S_FIRST;
          end
        end
      end
      S_DONE: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_offset    <= '0;
      r_len_m1    <= '0;
      r_lines_m1  <= '0;
      r_last_strb <= '0;
      r_word_cnt  <= '0;
      r_line_cnt  <= '0;
      r_h         <= '0;
    end else if (clear_i) begin
      r_offset    <= '0;
      r_len_m1    <= '0;
      r_lines_m1  <= '0;
      r_last_strb <= '0;
      r_word_cnt  <= '0;
      r_line_cnt  <= '0;
      r_h         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_word_cnt <= '0;
          r_line_cnt <= '0;
          if (start_i) begin
            r_offset    <= cfg_offset_i;
            r_len_m1    <= cfg_line_length_i - LEN_WIDTH'(1);
            r_lines_m1  <= cfg_num_lines_i - LEN_WIDTH'(1);
            r_last_strb <= cfg_last_strb_i;
          end
        end
        S_FIRST: begin
          if (w_in_hs) begin
            r_h <= stream_i.data;
          end
        end
        S_STREAM: begin
          if (w_out_hs) begin
            r_h <= stream_i.data;
            if (w_word_last) begin
              r_word_cnt <= '0;
              r_line_cnt <= w_line_last ? '0 : r_line_cnt + LEN_WIDTH'(1);
            end else begin
              r_word_cnt <= r_word_cnt + LEN_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          r_word_cnt <= '0;
          r_line_cnt <= '0;
        end
        default: begin
          r_word_cnt <= '0;
          r_line_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_stream_source_realign_line.sv
// Bench for the line realigner: table of jobs plus random jobs checked against
// a byte-addressed line model, and hand-written reset/clear abort sequences.
module tb_hwpe_stream_source_realign_line;

  localparam int unsigned DW = 32;
  localparam int unsigned B  = 4;
  localparam int unsigned LW = 16;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          start;
  logic [1:0]    cfg_off;
  logic [LW-1:0] cfg_len;
  logic [LW-1:0] cfg_lines;
  logic [B-1:0]  cfg_ls;
  logic          busy;
  logic          done;
  logic          line_last;

  hwpe_stream_source_realign_line_if #(.DATA_WIDTH(DW)) s_in ();
  hwpe_stream_source_realign_line_if #(.DATA_WIDTH(DW)) s_out ();

  hwpe_stream_source_realign_line #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .clear_i           (clear),
    .start_i           (start),
    .cfg_offset_i      (cfg_off),
    .cfg_line_length_i (cfg_len),
    .cfg_num_lines_i   (cfg_lines),
    .cfg_last_strb_i   (cfg_ls),
    .busy_o            (busy),
    .done_o            (done),
    .line_last_o       (line_last),
    .stream_i          (s_in),
    .stream_o          (s_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned off;
    int unsigned len;
    int unsigned lines;
    logic [3:0]  ls;
    int unsigned rdy_pct;
    int unsigned gap_pct;
    bit          ramp;
    bit          poke;
    int unsigned exp_in;
    int unsigned exp_out;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_strb[$];
  logic        exp_ll[$];
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_out_valid"}, 64'(s_out.valid), 0);
    check({tag, "_in_ready"}, 64'(s_in.ready), 0);
    check({tag, "_line_last"}, 64'(line_last), 0);
  endtask

  // Each line is a byte array starting at byte o of its first input word.
  function automatic void build_model(input int unsigned o, input int unsigned L,
                                      input int unsigned N, input logic [3:0] ls);
    int unsigned per;
    int unsigned idx;
    logic [31:0] w;
    logic [31:0] word;
    exp_data.delete();
    exp_strb.delete();
    exp_ll.delete();
    per = L + ((o > 0) ? 1 : 0);
    for (int unsigned l = 0; l < N; l++) begin
      for (int unsigned k = 0; k < L; k++) begin
        word = '0;
        for (int unsigned b = 0; b < B; b++) begin
          idx = o + k * B + b;
          w   = in_q[l * per + idx / B];
          word[8*b +: 8] = 8'((w >> (8 * (idx % B))) & 32'hFF);
        end
        exp_data.push_back(word);
        exp_strb.push_back((k == L - 1) ? ls : 4'hF);
        exp_ll.push_back(k == L - 1);
      end
    end
  endfunction

  task automatic run_job(input vec_t v);
    int unsigned n_in;
    int unsigned per;
    int          in_idx;
    int          out_idx;
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          last_hs;
    bit          hold;
    bit          rdy_seen;
    bit          st_pend;
    bit          empty;
    logic [31:0] st_d;
    logic [3:0]  st_s;
    logic        st_l;
    logic [31:0] w;

    empty = (v.len == 0) || (v.lines == 0);
    per   = v.len + ((v.off > 0) ? 1 : 0);
    n_in  = empty ? 0 : v.lines * per;
    in_q.delete();
    for (int unsigned i = 0; i < n_in; i++) begin
      if (v.ramp) begin
        for (int unsigned b = 0; b < B; b++) w[8*b +: 8] = 8'(4 * i + b);
      end else begin
        w = $urandom;
      end
      in_q.push_back(w);
    end
    build_model(v.off, v.len, v.lines, v.ls);
    got_q.delete();

    @(posedge clk); #1;
    cfg_off     = 2'(v.off);
    cfg_len     = LW'(v.len);
    cfg_lines   = LW'(v.lines);
    cfg_ls      = v.ls;
    start       = 1'b1;
    s_in.valid  = 1'b0;
    s_out.ready = 1'b0;
    @(posedge clk); #1;
    start     = 1'b0;
    cfg_off   = 2'($urandom);
    cfg_len   = LW'($urandom);
    cfg_lines = LW'($urandom);
    cfg_ls    = 4'($urandom);

    in_idx = 0; out_idx = 0; cyc = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
    hold = 0; rdy_seen = 0; st_pend = 0; st_d = '0; st_s = '0; st_l = 1'b0;

    while (1) begin
      if (in_idx < int'(n_in)) begin
        if (!hold) s_in.valid = ($urandom_range(99) >= v.gap_pct);
        hold      = s_in.valid;
        s_in.data = in_q[in_idx];
      end else begin
        s_in.valid = 1'b0;
        s_in.data  = $urandom;
      end
      s_out.ready = ($urandom_range(99) < v.rdy_pct);
      start       = v.poke && (cyc == 3);
      if (start) begin
        cfg_off   = 2'd0;
        cfg_len   = LW'(1);
        cfg_lines = LW'(1);
      end
      @(negedge clk);
      if (done_cnt > 0) begin
        check("busy_after_done", 64'(busy), 0);
        check("done_single_pulse", 64'(done), 0);
        break;
      end
      check("busy_in_job", 64'(busy), 1);
      if (s_in.ready) rdy_seen = 1;
      if (st_pend) begin
        check("stall_valid_held", 64'(s_out.valid), 1);
        check("stall_data_held", 64'(s_out.data), 64'(st_d));
        check("stall_strb_held", 64'(s_out.strb), 64'(st_s));
        check("stall_line_last_held", 64'(line_last), 64'(st_l));
      end
      if (s_out.valid && s_out.ready) begin
        if (out_idx < exp_data.size()) begin
          check($sformatf("out_data[%0d]", out_idx), 64'(s_out.data), 64'(exp_data[out_idx]));
          check($sformatf("out_strb[%0d]", out_idx), 64'(s_out.strb), 64'(exp_strb[out_idx]));
          check($sformatf("line_last[%0d]", out_idx), 64'(line_last), 64'(exp_ll[out_idx]));
        end else begin
          check("out_overrun", 64'(out_idx), 64'(exp_data.size()));
        end
        got_q.push_back(s_out.data);
        out_idx++;
        last_hs = cyc;
      end
      st_pend = s_out.valid && !s_out.ready;
      st_d    = s_out.data;
      st_s    = s_out.strb;
      st_l    = line_last;
      if (s_in.valid && s_in.ready) begin
        in_idx++;
        hold = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      cyc++;
      if (cyc >= 3000) begin
        check("job_timeout_done_seen", 64'(done_cnt), 1);
        break;
      end
      @(posedge clk); #1;
    end

    start       = 1'b0;
    s_in.valid  = 1'b0;
    s_out.ready = 1'b0;
    check("inputs_consumed", 64'(in_idx), 64'(v.exp_in));
    check("outputs_produced", 64'(out_idx), 64'(v.exp_out));
    check("done_count", 64'(done_cnt), 1);
    if (empty) begin
      check("empty_done_latency", 64'(done_cyc), 0);
      check("empty_in_ready_seen", 64'(rdy_seen), 0);
    end else begin
      check("done_after_last_hs", 64'(done_cyc - last_hs), 1);
    end
  endtask

  task automatic abort_mid(input bit use_rst);
    @(posedge clk); #1;
    cfg_off = 2'd1; cfg_len = LW'(3); cfg_lines = LW'(1); cfg_ls = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_in.valid = 1'b1; s_in.data = $urandom; s_out.ready = 1'b1;
    @(posedge clk); #1;
    s_in.data = $urandom;
    @(posedge clk); #1;
    s_in.data = $urandom;
    @(negedge clk);
    check("abort_busy_before", 64'(busy), 1);
    check("abort_valid_before", 64'(s_out.valid), 1);
    check("abort_word1_not_last", 64'(line_last), 0);
    if (use_rst) begin
      #2;
      rst = 1'b1;
      #1;
      check_idle("async_reset");
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check_idle("clear");
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 0);
      check("abort_stays_idle", 64'(busy), 0);
    end
    s_in.valid  = 1'b0;
    s_out.ready = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rv;

    rst = 1'b1; clear = 1'b0; start = 1'b0;
    cfg_off = '0; cfg_len = '0; cfg_lines = '0; cfg_ls = '0;
    s_in.valid = 1'b0; s_in.data = '0; s_in.strb = '1; s_out.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    tbl[0] = '{1, 2, 1, 4'hF, 100,  0, 1'b1, 1'b0,  3,  2};
    tbl[1] = '{0, 3, 2, 4'h3, 100,  0, 1'b0, 1'b0,  6,  6};
    tbl[2] = '{3, 1, 3, 4'h6, 100,  0, 1'b0, 1'b0,  6,  3};
    tbl[3] = '{2, 4, 2, 4'h7,  30, 30, 1'b0, 1'b1, 10,  8};
    tbl[4] = '{1, 0, 3, 4'h1, 100,  0, 1'b0, 1'b0,  0,  0};
    tbl[5] = '{2, 5, 0, 4'h1, 100,  0, 1'b0, 1'b0,  0,  0};
    tbl[6] = '{1, 5, 2, 4'h1,  60, 20, 1'b0, 1'b0, 12, 10};
    tbl[7] = '{0, 1, 1, 4'h8,  50, 50, 1'b0, 1'b0,  1,  1};

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i]);
      if (i == 0) begin
        check("ramp_word0", 64'(got_q.size() > 0 ? got_q[0] : 32'h0), 64'h04030201);
        check("ramp_word1", 64'(got_q.size() > 1 ? got_q[1] : 32'h0), 64'h08070605);
      end
    end

    for (int i = 0; i < 6; i++) begin
      rv.off     = $urandom_range(3);
      rv.len     = $urandom_range(6, 1);
      rv.lines   = $urandom_range(4, 1);
      rv.ls      = 4'($urandom);
      rv.rdy_pct = $urandom_range(90, 30);
      rv.gap_pct = $urandom_range(40);
      rv.ramp    = 1'b0;
      rv.poke    = 1'b0;
      rv.exp_in  = rv.lines * (rv.len + ((rv.off > 0) ? 1 : 0));
      rv.exp_out = rv.lines * rv.len;
      run_job(rv);
    end

    abort_mid(1'b1);
    rv = '{2, 2, 1, 4'h3, 100, 0, 1'b0, 1'b0, 3, 2};
    run_job(rv);
    abort_mid(1'b0);
    rv = '{1, 3, 2, 4'h7, 70, 10, 1'b0, 1'b0, 8, 6};
    run_job(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
